// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PIPE fetch sequencer: FSM states, next-PC select codes
// and the saturating ret/halt wait counter helper.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    PCC_BOOT     = 3'd0,
    PCC_RUN      = 3'd1,
    PCC_RETWAIT  = 3'd2,
    PCC_HALTPEND = 3'd3,
    PCC_HALTED   = 3'd4
  } pcc_state_e;

  typedef enum logic [3:0] {
    SEL_HOLD = 4'b0001,
    SEL_PRED = 4'b0010,
    SEL_VALA = 4'b0100,
    SEL_VALM = 4'b1000
  } pc_sel_e;

  localparam int CNT_W         = 3;
  localparam int HALT_PEND_CYC = 2;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC multiplexer: prediction, mispredict fall-through, ret address or hold.
module pc_next_sel
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W = 48
) (
  input  pc_sel_e         i_sel,
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_pred_pc,
  input  logic [PC_W-1:0] i_vala,
  input  logic [PC_W-1:0] i_valm,
  output logic [PC_W-1:0] o_next_pc
);

  always_comb begin
    o_next_pc = i_pc;
    unique case (i_sel)
      SEL_PRED: o_next_pc = i_pred_pc;
      SEL_VALA: o_next_pc = i_vala;
      SEL_VALM: o_next_pc = i_valm;
      default:  o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Y86 PIPE fetch sequencer: owns the PC and drives F/D/E stall and bubble
// controls for mispredicts, load-use hazards, ret waits and halt draining.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              PC_W        = 48,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              RET_TIMEOUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] f_predPC,
  input  logic            f_is_ret,
  input  logic            f_halt,
  input  logic            d_loaduse,
  input  logic            e_mispredict,
  input  logic [PC_W-1:0] e_valA,
  input  logic            w_ret_done,
  input  logic [PC_W-1:0] w_valM,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            stall_f,
  output logic            stall_d,
  output logic            bubble_d,
  output logic            bubble_e,
  output logic            halted,
  output logic            err
);

  pcc_state_e       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [PC_W-1:0]  r_pc, w_pc_nx;
  logic             r_halted, r_err, w_err_set;
  pc_sel_e          w_sel;

  pc_next_sel #(.PC_W(PC_W)) u_next_sel (
    .i_sel     (w_sel),
    .i_pc      (r_pc),
    .i_pred_pc (f_predPC),
    .i_vala    (e_valA),
    .i_valm    (w_valM),
    .o_next_pc (w_pc_nx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= PCC_BOOT;
      r_pc     <= RESET_PC;
      r_cnt    <= '0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_cnt    <= w_cnt_nx;
      r_halted <= (w_state_nx == PCC_HALTED);
      r_err    <= r_err | w_err_set;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sel      = SEL_HOLD;
    w_err_set  = 1'b0;
    pc_valid   = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    bubble_d   = 1'b0;
    bubble_e   = 1'b0;
    unique case (r_state)
      PCC_BOOT: w_state_nx = PCC_RUN;
      PCC_RUN: begin
        pc_valid = 1'b1;
        if (e_mispredict) begin
          w_sel    = SEL_VALA;
          bubble_d = 1'b1;
          bubble_e = 1'b1;
        end else if (d_loaduse) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          bubble_e = 1'b1;
        end else if (f_is_ret) begin
          stall_f    = 1'b1;
          bubble_d   = 1'b1;
          w_state_nx = PCC_RETWAIT;
          w_cnt_nx   = '0;
        end else if (f_halt) begin
          stall_f    = 1'b1;
          pc_valid   = 1'b0;
          w_state_nx = PCC_HALTPEND;
          w_cnt_nx   = '0;
        end else begin
          w_sel = SEL_PRED;
        end
      end
      PCC_RETWAIT: begin
        pc_valid = 1'b1;
        // A mispredict means the ret itself was fetched down the wrong path.
        if (e_mispredict) begin
          w_sel      = SEL_VALA;
          bubble_d   = 1'b1;
          bubble_e   = 1'b1;
          w_state_nx = PCC_RUN;
        end else if (w_ret_done) begin
          w_sel      = SEL_VALM;
          w_state_nx = PCC_RUN;
        end else begin
          stall_f  = 1'b1;
          bubble_d = 1'b1;
          if (r_cnt >= CNT_W'(RET_TIMEOUT - 1)) begin
            w_err_set  = 1'b1;
            w_state_nx = PCC_HALTED;
          end else begin
            w_cnt_nx = cnt_sat_inc(r_cnt);
          end
        end
      end
      PCC_HALTPEND: begin
        if (e_mispredict) begin
          w_sel      = SEL_VALA;
          bubble_d   = 1'b1;
          bubble_e   = 1'b1;
          w_state_nx = PCC_RUN;
        end else begin
          stall_f = 1'b1;
          if (r_cnt >= CNT_W'(HALT_PEND_CYC - 1)) w_state_nx = PCC_HALTED;
          else                                    w_cnt_nx   = cnt_sat_inc(r_cnt);
        end
      end
      PCC_HALTED: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
      end
      default: w_state_nx = PCC_BOOT;
    endcase
  end

  assign pc     = r_pc;
  assign halted = r_halted;
  assign err    = r_err;

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Fetch sequencer and pipeline-control unit for the Y86 PIPE core. It owns the program counter: each cycle it selects the next PC from the fetch prediction, a mispredict fall-through, or a returned address. It generates the stall/bubble controls for F/D/E. It also handles `ret` wait, load-use hazards and halt draining.

Parameters:
PC_W, 48, PC width (matches `PCLEN`)
RESET_PC, 48'h0, first fetch address after reset
RET_TIMEOUT, 4, maximum RET_WAIT cycles before a protocol error is flagged

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-low (rst==0 resets on the clock edge)
f_predPC  in  PC_W  fetch-stage predicted next PC (valC for jXX/call, else valP)
f_is_ret  in  1  instruction in F is ret
f_halt  in  1  instruction in F is halt or invalid
d_loaduse  in  1  load-use hazard: D needs the result of mrmovl/popl in E
e_mispredict  in  1  conditional jump in E resolved not-taken
e_valA  in  PC_W  fall-through PC of the mispredicted jump
w_ret_done  in  1  ret is in W this cycle
w_valM  in  PC_W  return address read by the ret
pc  out  PC_W  current fetch address
pc_valid  out  1  pc is a real fetch
stall_f  out  1  hold the F register
stall_d  out  1  hold the D register
bubble_d  out  1  inject a nop into D
bubble_e  out  1  inject a nop into E
halted  out  1  core stopped
err  out  1  ret timeout; sticky until reset

Behaviour:
- State register, pc, halted and err are all registered. stall/bubble outputs are combinational from state and inputs.
- Reset (rst==0 at an edge):
  - pc=RESET_PC, state=BOOT, pc_valid=0, halted=0, err=0, ret counter=0.
  - All stall/bubble outputs are 0 while in BOOT.
  - Reset overrides everything, including mid-RET_WAIT and HALTED.
- BOOT -> RUN unconditionally. pc stays RESET_PC; pc_valid=1 from RUN onward.
- RUN, per-cycle priority (highest first):
  1. e_mispredict: pc<=e_valA; bubble_d=1, bubble_e=1. Any f_is_ret/f_halt in the same cycle is ignored (wrong path).
  2. d_loaduse: stall_f=1, stall_d=1, bubble_e=1; pc holds. A coincident f_is_ret is re-evaluated next cycle.
  3. f_is_ret: pc holds, stall_f=1, bubble_d=1; state->RET_WAIT, counter=0.
  4. f_halt: pc holds, stall_f=1, pc_valid=0; state->HALT_PEND, counter=0.
  5. Otherwise: pc<=f_predPC.
- RET_WAIT:
  - Every cycle: stall_f=1, bubble_d=1, pc holds.
  - w_ret_done: pc<=w_valM; state->RUN; stall_f/bubble_d deasserted that cycle.
  - e_mispredict (ret was on the wrong path): pc<=e_valA; bubble_d=1, bubble_e=1; ->RUN.
  - If counter reaches RET_TIMEOUT without w_ret_done: err<=1, ->HALTED.
- HALT_PEND (2 cycles, to let older jumps resolve):
  - stall_f=1, pc_valid=0.
  - e_mispredict: pc<=e_valA, bubble_d=1, bubble_e=1, pc_valid=1 next cycle, ->RUN.
  - After the 2nd cycle with no mispredict: ->HALTED.
- HALTED:
  - halted=1, pc_valid=0, stall_f=1, stall_d=1; pc frozen.
  - All inputs are ignored; only reset exits.
- Width rules: pc is loaded verbatim; no arithmetic is done here (valP is computed in fetch). The counter is 3 bits and saturates.

Decomposition:
- defines.v additions: state encodings `PCC_BOOT`, `PCC_RUN`, `PCC_RETWAIT`, `PCC_HALTPEND`, `PCC_HALTED`; `PCLEN` reused for PC_W.
- One natural sub-module, pc_next_sel: combinational next-PC mux (f_predPC / e_valA / w_valM / hold) with a one-hot select driven by the FSM.
- Everything else stays in pc_ctrl.

Test Plan:
- Reset/boot: hold rst=0 two cycles, then release -> pc=0, pc_valid=0 in BOOT; next cycle pc_valid=1. Then f_predPC=0x6 -> pc=0x6 on the following edge.
- Load-use: in RUN at pc=0x10, assert d_loaduse one cycle -> stall_f=stall_d=bubble_e=1, pc stays 0x10. Next cycle with f_predPC=0x16 -> pc=0x16.
- Ret: f_is_ret at pc=0x20 -> RET_WAIT with stall_f=bubble_d=1 for 3 cycles. Then w_ret_done with w_valM=0x40 -> pc=0x40, state RUN. Variant with no w_ret_done for 4 cycles -> err=1, halted=1.
- Mispredict: pc=0x30, e_mispredict=1, e_valA=0x2A, with f_is_ret=1 simultaneously -> pc=0x2A, bubble_d=bubble_e=1, no RET_WAIT entered.
- Halt: f_halt at pc=0x50 with no mispredict -> HALTED after 2 cycles, pc stays 0x50. Variant with e_mispredict (e_valA=0x48) on HALT_PEND cycle 1 -> pc=0x48, RUN, pc_valid=1.
- Reset mid-operation: rst=0 during RET_WAIT and during HALTED -> next edge pc=RESET_PC, halted=0, err=0, state BOOT.
